// File: rtl/alu_exec_if.sv
// Handshake bundle for alu_exec_unit: command channel in, result channel out.
// The consumer-facing side of the unit is the slave modport.
interface alu_exec_if #(
    parameter int N = 16
) ();
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   alu_op;
    logic [N-1:0] operand_a;
    logic [N-1:0] operand_b;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] result;
    logic         zero_flag;
    logic         carry_flag;

    modport slave (
        input  in_valid, alu_op, operand_a, operand_b, out_ready,
        output in_ready, out_valid, result, zero_flag, carry_flag
    );

    modport master (
        output in_valid, alu_op, operand_a, operand_b, out_ready,
        input  in_ready, out_valid, result, zero_flag, carry_flag
    );
endinterface

// File: rtl/alu_exec_unit.sv
// Valid/ready ALU: single-cycle ADD/SUB/AND, N-cycle shift-add MUL,
// result and flags held in DONE until the consumer takes them.
module alu_exec_unit #(
    parameter int N = 16
) (
    input  logic      clk,
    input  logic      rst,
    alu_exec_if.slave bus
);
    localparam int CW = $clog2(N) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         r_state;
    logic [2*N-1:0] r_acc;
    logic [2*N-1:0] r_mcand;
    logic [N-1:0]   r_mplier;
    logic [CW-1:0]  r_cnt;
    logic [N-1:0]   r_result;
    logic           r_zero;
    logic           r_carry;
    logic           r_out_valid;

    logic [N:0]     w_sum;
    logic [N:0]     w_diff;
    logic [N-1:0]   w_alu_res;
    logic           w_alu_carry;
    logic [2*N-1:0] w_acc_next;

    // Single-cycle operations; bit N of the (N+1)-bit difference is the borrow.
    always_comb begin
        w_sum       = {1'b0, bus.operand_a} + {1'b0, bus.operand_b};
        w_diff      = {1'b0, bus.operand_a} - {1'b0, bus.operand_b};
        w_alu_res   = '0;
        w_alu_carry = 1'b0;
        case (bus.alu_op)
            2'd0: begin
                w_alu_res   = w_sum[N-1:0];
                w_alu_carry = w_sum[N];
            end
            2'd1: begin
                w_alu_res   = w_diff[N-1:0];
                w_alu_carry = w_diff[N];
            end
            2'd2: begin
                w_alu_res   = bus.operand_a & bus.operand_b;
                w_alu_carry = 1'b0;
            end
            default: begin
                w_alu_res   = '0;
                w_alu_carry = 1'b0;
            end
        endcase
    end

    // One shift-add step: add the shifted multiplicand when the current multiplier LSB is set.
    always_comb begin
        if (r_mplier[0]) begin
            w_acc_next = r_acc + r_mcand;
        end else begin
            w_acc_next = r_acc;
        end
    end

    assign bus.in_ready   = (r_state == S_IDLE) && !rst;
    assign bus.out_valid  = r_out_valid;
    assign bus.result     = r_result;
    assign bus.zero_flag  = r_zero;
    assign bus.carry_flag = r_carry;

    // Control FSM with datapath registers; reset discards any in-flight command.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_cnt       <= '0;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_carry     <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        if (bus.alu_op == 2'd3) begin
                            r_acc    <= '0;
                            r_mcand  <= {{N{1'b0}}, bus.operand_a};
                            r_mplier <= bus.operand_b;
                            r_cnt    <= '0;
                            r_state  <= S_MUL;
                        end else begin
                            r_result    <= w_alu_res;
                            r_zero      <= (w_alu_res == '0);
                            r_carry     <= w_alu_carry;
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_MUL: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CW'(1);
                    if (r_cnt == CW'(N - 1)) begin
                        r_result    <= w_acc_next[N-1:0];
                        r_zero      <= (w_acc_next[N-1:0] == '0);
                        r_carry     <= |w_acc_next[2*N-1:N];
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_state <= S_MUL;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end else begin
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end
endmodule
